// File: rtl/regex_instr_mem_responder.sv
// Instruction memory responder for the regex CPU fetch ports.
// Two read ports and one host write port share a single-ported instruction
// store. A host write always wins the cycle. Read conflicts are resolved
// round-robin. Read data is registered and appears one cycle after the grant.
// The stall counter saturates and counts the cycles in which a read was refused.
module regex_instr_mem_responder #(
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int STALL_COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         memory_valid_0,
  input  logic [MEMORY_ADDR_WIDTH-1:0] memory_addr_0,
  output logic                         memory_ready_0,
  output logic [MEMORY_WIDTH-1:0]      memory_data_0,
  input  logic                         memory_valid_1,
  input  logic [MEMORY_ADDR_WIDTH-1:0] memory_addr_1,
  output logic                         memory_ready_1,
  output logic [MEMORY_WIDTH-1:0]      memory_data_1,
  input  logic                         wr_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0] wr_addr,
  input  logic [MEMORY_WIDTH-1:0]      wr_data,
  output logic                         wr_ready,
  output logic [STALL_COUNT_WIDTH-1:0] stall_count
);

  localparam int DEPTH = 2 ** MEMORY_ADDR_WIDTH;
  localparam logic [STALL_COUNT_WIDTH-1:0] STALL_ONE = {{(STALL_COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [STALL_COUNT_WIDTH-1:0] STALL_MAX = {STALL_COUNT_WIDTH{1'b1}};

  // Instruction store. It has no reset, so the program survives a CPU reset.
  logic [MEMORY_WIDTH-1:0] store_r [0:DEPTH-1];

  // The round-robin pointer is 0 when port 0 is preferred and 1 when port 1 is preferred.
  logic                         prefer_1_r;
  logic [MEMORY_WIDTH-1:0]      data_0_r;
  logic [MEMORY_WIDTH-1:0]      data_1_r;
  logic [STALL_COUNT_WIDTH-1:0] stall_count_r;

  logic                         grant_wr_s;
  logic                         grant_0_s;
  logic                         grant_1_s;
  logic                         refused_s;
  logic [MEMORY_ADDR_WIDTH-1:0] rd_addr_s;
  logic [MEMORY_WIDTH-1:0]      rd_data_s;
  logic [STALL_COUNT_WIDTH-1:0] stall_next_s;

  // Arbitrate the single store access. A write wins first, then a lone reader, then the preferred reader.
  always_comb begin
    grant_wr_s = 1'b0;
    grant_0_s  = 1'b0;
    grant_1_s  = 1'b0;
    if (!reset) begin
      grant_wr_s = 1'b0;
      grant_0_s  = 1'b0;
      grant_1_s  = 1'b0;
    end else if (wr_valid) begin
      grant_wr_s = 1'b1;
    end else begin
      case ({memory_valid_1, memory_valid_0})
        2'b01:   grant_0_s = 1'b1;
        2'b10:   grant_1_s = 1'b1;
        2'b11: begin
          grant_0_s = ~prefer_1_r;
          grant_1_s = prefer_1_r;
        end
        default: begin
          grant_0_s = 1'b0;
          grant_1_s = 1'b0;
        end
      endcase
    end
  end

  // Steer the single read port to whichever reader holds the grant.
  always_comb begin
    rd_addr_s = memory_addr_0;
    if (grant_1_s) begin
      rd_addr_s = memory_addr_1;
    end else begin
      rd_addr_s = memory_addr_0;
    end
  end

  assign rd_data_s = store_r[rd_addr_s];

  // A cycle is a stall if any valid reader went without a grant. The counter sticks at all-ones.
  always_comb begin
    refused_s    = (memory_valid_0 & ~grant_0_s) | (memory_valid_1 & ~grant_1_s);
    stall_next_s = stall_count_r;
    if (refused_s && (stall_count_r != STALL_MAX)) begin
      stall_next_s = stall_count_r + STALL_ONE;
    end else begin
      stall_next_s = stall_count_r;
    end
  end

  // Host program load. The grant is already masked by reset, so a write cannot slip through during reset.
  always_ff @(posedge clk) begin
    if (grant_wr_s) begin
      store_r[wr_addr] <= wr_data;
    end
  end

  // Registered read data, the round-robin pointer and the stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_0_r      <= {MEMORY_WIDTH{1'b0}};
      data_1_r      <= {MEMORY_WIDTH{1'b0}};
      prefer_1_r    <= 1'b0;
      stall_count_r <= {STALL_COUNT_WIDTH{1'b0}};
    end else begin
      stall_count_r <= stall_next_s;
      if (grant_0_s) begin
        data_0_r   <= rd_data_s;
        prefer_1_r <= 1'b1;
      end else if (grant_1_s) begin
        data_1_r   <= rd_data_s;
        prefer_1_r <= 1'b0;
      end
    end
  end

  assign memory_ready_0 = grant_0_s;
  assign memory_ready_1 = grant_1_s;
  assign wr_ready       = grant_wr_s;
  assign memory_data_0  = data_0_r;
  assign memory_data_1  = data_1_r;
  assign stall_count    = stall_count_r;

endmodule

// File: tb/tb_regex_instr_mem_responder.sv
// Directed testbench for regex_instr_mem_responder: program load, arbitration,
// write priority, read latency, async reset and stall-counter saturation.
module tb_regex_instr_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_0, valid_1, wr_valid;
  logic [10:0] addr_0, addr_1, wr_addr;
  logic [15:0] wr_data;
  logic        ready_0, ready_1, wr_ready;
  logic [15:0] data_0, data_1, stall_count;

  logic        sat_valid_0, sat_valid_1;
  logic        sat_ready_0, sat_ready_1, sat_wr_ready;
  logic [15:0] sat_data_0, sat_data_1;
  logic [3:0]  sat_stall;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [15:0] exp_d0, exp_d1;

  always #5 clk = ~clk;

  regex_instr_mem_responder dut (
    .clk(clk), .reset(reset),
    .memory_valid_0(valid_0), .memory_addr_0(addr_0), .memory_ready_0(ready_0), .memory_data_0(data_0),
    .memory_valid_1(valid_1), .memory_addr_1(addr_1), .memory_ready_1(ready_1), .memory_data_1(data_1),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .stall_count(stall_count)
  );

  regex_instr_mem_responder #(.STALL_COUNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset),
    .memory_valid_0(sat_valid_0), .memory_addr_0(11'd3), .memory_ready_0(sat_ready_0), .memory_data_0(sat_data_0),
    .memory_valid_1(sat_valid_1), .memory_addr_1(11'd4), .memory_ready_1(sat_ready_1), .memory_data_1(sat_data_1),
    .wr_valid(1'b0), .wr_addr(11'd0), .wr_data(16'd0), .wr_ready(sat_wr_ready),
    .stall_count(sat_stall)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [10:0] a, input logic [15:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    #1;
    check_eq("wr_ready", {31'd0, wr_ready}, 32'd1);
    step();
    wr_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    valid_0 = 1'b0; valid_1 = 1'b0; wr_valid = 1'b0;
    addr_0 = 11'd0; addr_1 = 11'd0; wr_addr = 11'd0; wr_data = 16'd0;
    sat_valid_0 = 1'b0; sat_valid_1 = 1'b0;

    // Under reset, requests are not granted and the registered outputs stay at zero.
    #2;
    valid_0 = 1'b1; addr_0 = 11'd1; wr_valid = 1'b1; wr_addr = 11'd7; wr_data = 16'hDEAD;
    #1;
    check_eq("rst_ready0", {31'd0, ready_0}, 32'd0);
    check_eq("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    step();
    step();
    check_eq("rst_data0", {16'd0, data_0}, 32'd0);
    check_eq("rst_data1", {16'd0, data_1}, 32'd0);
    check_eq("rst_stall", {16'd0, stall_count}, 32'd0);
    check_eq("rst_sat_stall", {28'd0, sat_stall}, 32'd0);
    valid_0 = 1'b0; wr_valid = 1'b0;
    reset = 1'b1;
    step();

    // Load the program.
    host_write(11'd1, 16'h00A1);
    host_write(11'd2, 16'h00B2);
    host_write(11'd5, 16'h1234);

    // Contention: grants alternate 0,1,0,1 and each data word updates only after its own grant.
    valid_0 = 1'b1; addr_0 = 11'd1;
    valid_1 = 1'b1; addr_1 = 11'd2;
    exp_d0 = 16'h0000; exp_d1 = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("cont_ready0", {31'd0, ready_0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("cont_ready1", {31'd0, ready_1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
      if (i % 2 == 0) exp_d0 = 16'h00A1;
      else            exp_d1 = 16'h00B2;
      check_eq("cont_data0", {16'd0, data_0}, {16'd0, exp_d0});
      check_eq("cont_data1", {16'd0, data_1}, {16'd0, exp_d1});
    end
    check_eq("cont_stall", {16'd0, stall_count}, 32'd4);
    valid_0 = 1'b0; valid_1 = 1'b0;

    // Load/read: port 0 reads addr 5. The data arrives one cycle later and then holds.
    valid_0 = 1'b1; addr_0 = 11'd5;
    #1;
    check_eq("load_ready0", {31'd0, ready_0}, 32'd1);
    step();
    check_eq("load_data0", {16'd0, data_0}, 32'h1234);
    valid_0 = 1'b0;
    valid_1 = 1'b1; addr_1 = 11'd1;
    #1;
    check_eq("load_ready1", {31'd0, ready_1}, 32'd1);
    step();
    check_eq("hold_data0_a", {16'd0, data_0}, 32'h1234);
    check_eq("p1_data1", {16'd0, data_1}, 32'h00A1);
    valid_1 = 1'b0;
    step();
    check_eq("hold_data0_b", {16'd0, data_0}, 32'h1234);

    // Write priority: 3 write cycles block both readers and leave the pointer at port 0.
    wr_valid = 1'b1; wr_addr = 11'd20; wr_data = 16'h5555;
    valid_0 = 1'b1; addr_0 = 11'd1;
    valid_1 = 1'b1; addr_1 = 11'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("wp_wr_ready", {31'd0, wr_ready}, 32'd1);
      check_eq("wp_ready0", {31'd0, ready_0}, 32'd0);
      check_eq("wp_ready1", {31'd0, ready_1}, 32'd0);
      step();
    end
    check_eq("wp_stall", {16'd0, stall_count}, 32'd7);
    wr_valid = 1'b0;
    #1;
    check_eq("wp_rr_ready0", {31'd0, ready_0}, 32'd1);
    check_eq("wp_rr_ready1", {31'd0, ready_1}, 32'd0);
    step();
    check_eq("wp_data0", {16'd0, data_0}, 32'h00A1);
    check_eq("wp_stall2", {16'd0, stall_count}, 32'd8);
    valid_0 = 1'b0; valid_1 = 1'b0;

    // Write-then-read: a write at edge N is visible to a read accepted at edge N+1.
    wr_valid = 1'b1; wr_addr = 11'd9; wr_data = 16'hBEEF;
    step();
    wr_valid = 1'b0;
    valid_1 = 1'b1; addr_1 = 11'd9;
    #1;
    check_eq("wtr_ready1", {31'd0, ready_1}, 32'd1);
    step();
    check_eq("wtr_data1", {16'd0, data_1}, 32'hBEEF);
    valid_1 = 1'b0;

    // Back-to-back reads: a lone port is granted every cycle with fresh data each time.
    valid_0 = 1'b1;
    addr_0 = 11'd1; #1; check_eq("b2b_ready_a", {31'd0, ready_0}, 32'd1); step(); check_eq("b2b_a", {16'd0, data_0}, 32'h00A1);
    addr_0 = 11'd2; #1; check_eq("b2b_ready_b", {31'd0, ready_0}, 32'd1); step(); check_eq("b2b_b", {16'd0, data_0}, 32'h00B2);
    addr_0 = 11'd5; #1; check_eq("b2b_ready_c", {31'd0, ready_0}, 32'd1); step(); check_eq("b2b_c", {16'd0, data_0}, 32'h1234);
    addr_0 = 11'd9; #1; check_eq("b2b_ready_d", {31'd0, ready_0}, 32'd1); step(); check_eq("b2b_d", {16'd0, data_0}, 32'hBEEF);
    check_eq("b2b_stall", {16'd0, stall_count}, 32'd8);

    // Async reset mid-stream. The pointer now prefers port 1, and reset must restore port 0 priority.
    valid_0 = 1'b1; addr_0 = 11'd1;
    valid_1 = 1'b1; addr_1 = 11'd2;
    #1;
    check_eq("pre_rst_ready1", {31'd0, ready_1}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_ready0", {31'd0, ready_0}, 32'd0);
    check_eq("arst_ready1", {31'd0, ready_1}, 32'd0);
    check_eq("arst_data0", {16'd0, data_0}, 32'd0);
    check_eq("arst_data1", {16'd0, data_1}, 32'd0);
    check_eq("arst_stall", {16'd0, stall_count}, 32'd0);
    step();
    check_eq("arst_hold_data1", {16'd0, data_1}, 32'd0);
    reset = 1'b1;
    #1;
    check_eq("post_rst_ready0", {31'd0, ready_0}, 32'd1);
    check_eq("post_rst_ready1", {31'd0, ready_1}, 32'd0);
    step();
    check_eq("post_rst_data0", {16'd0, data_0}, 32'h00A1);
    check_eq("post_rst_data1", {16'd0, data_1}, 32'd0);
    valid_0 = 1'b0; valid_1 = 1'b0;

    // Saturation: a 4-bit counter with 20 refused cycles stops at 15.
    sat_valid_0 = 1'b1; sat_valid_1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("sat_stall", {28'd0, sat_stall}, (i + 1 < 15) ? (i + 1) : 15);
    end
    sat_valid_0 = 1'b0; sat_valid_1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
